montgomery_exp_ctrl: RTL
========================

# montgomery_exp_ctrl

Sequencer that computes modular exponentiation x^e mod M by driving one external `montgomery` multiplier instance (512-bit, start/done handshake) with left-to-right square-and-multiply. It sits between the top-level RSA register interface and the `montgomery` core. It owns operand selection, the exponent bit scan, intermediate-result storage and conversion into and out of the Montgomery domain.

## Interface
- `EXP_W`, default 512: exponent width in bits. Legal range 2..512.
- `clk` in 1: single clock, rising-edge.
- `resetn` in 1: asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- `start` in 1: one-cycle request. Accepted only in IDLE.
- `in_x` in 512: base, x < M.
- `in_e` in EXP_W: exponent.
- `in_m` in 512: modulus, odd.
- `in_r` in 512: R mod M, with R = 2^512.
- `in_r2` in 512: R^2 mod M.
- `busy` out 1: high from the cycle after start is accepted until `done`.
- `done` out 1: one-cycle pulse when `result` becomes valid.
- `result` out 512: x^e mod M. Held until the next accepted start.
- `mm_start` out 1: one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m` out 512 each: multiplier operands. Stable from `mm_start` until `mm_done`.
- `mm_result` in 512: multiplier output.
- `mm_done` in 1: multiplier completion.

## Operation
- On an accepted start, latch `in_x`, `in_e`, `in_m`, `in_r2`. Set accumulator A = `in_r` and bit index i = EXP_W-1.
- Operation order:
  1. TOX: Xm = MM(x, R2).
  2. For i from EXP_W-1 down to 0: SQR computes A = MM(A, A). If e[i] = 1, MUL then computes A = MM(A, Xm).
  3. OUT: result = MM(A, 1).
- State machine:
  - IDLE: on start, go to ISSUE with op = TOX.
  - ISSUE: one cycle. Assert `mm_start` and drive the operands for the current op. Go to WAIT.
  - WAIT: hold the operands and wait for `mm_done`. On `mm_done`, capture `mm_result` into Xm (for TOX), A (for SQR/MUL) or `result` (for OUT). Select the next op. Go to ISSUE, or to FIN after OUT.
  - FIN: pulse `done`, clear `busy`, go to IDLE.
- Next-op selection:
  - After TOX: SQR.
  - After SQR: MUL if e[i] = 1; otherwise decrement i, then SQR, or OUT once bit 0 is processed.
  - After MUL: decrement i, then SQR, or OUT once bit 0 is processed.
- `mm_m` always equals the latched M. For OUT, `mm_b` = 512'd1.
- Boundary rules:
  - e = 0: result = 1 (A stays R; MM(R, 1) = 1).
  - `start` while busy is ignored. Latched operands are unaffected.
  - `mm_done` outside WAIT is ignored.
  - Input changes after acceptance have no effect.
- Reset (including mid-operation):
  - State returns to IDLE.
  - `busy`, `done`, `mm_start` = 0.
  - `result`, `mm_a`, `mm_b`, `mm_m` = 0.
  - Any in-flight multiplier result is discarded. The multiplier shares `resetn`.

## Timing
- Start is sampled at the rising edge in IDLE. `busy` and the first `mm_start` are high in the following cycle.
- For each op: `mm_start` lasts 1 cycle, then the block waits for `mm_done`. `mm_start` for the next op occurs exactly 1 cycle after the cycle in which `mm_done` is sampled.
- Let L = multiplier latency in cycles (`mm_start` to `mm_done`) and N = number of ops. Total latency from the start edge to the `done` pulse = N·(L+1) + 1 cycles.
- N = 2 + (number of scanned bits) + popcount(e).
- `done` and the final `result` update are in the same cycle; `busy` falls in that cycle.

## Configuration
- `SKIP_LEADING_ZEROS_EN` defined:
  - After TOX, i is decremented one bit per cycle with no multiplication while e[i] = 0, until the first 1 bit. Scanned bits = msb(e)+1.
  - If e = 0, go directly to OUT.
  - Execution time then depends on the exponent.
- Undefined: all EXP_W bits are squared (scanned bits = EXP_W). Squaring count is independent of the exponent.

## Test plan
- EXP_W = 16, M = 1009, x = 2, e = 10, R/R2 precomputed by the bench -> `result` = 15, one `done` pulse, `busy` low afterwards.
- e = 0 -> `result` = 1. e = 1 -> `result` = x. The bench uses the real `montgomery` with a 512-bit odd M.
- EXP_W = 16, e = 1: count `mm_start` pulses -> 19 without the macro, 4 with `SKIP_LEADING_ZEROS_EN`.
- `start` pulsed again mid-run with different `in_x` -> ignored; result still matches the first request, and exactly one `done` pulse.
- `resetn` asserted while in WAIT -> all outputs 0 immediately. A fresh start after release yields the correct result.
- Random 512-bit M/x/e checked against the bench reference model. Check latency = N·(L+1) + 1 and that `mm_a`/`mm_b` stay stable through each WAIT.

Source files
------------

// File: rtl/montgomery_exp_ctrl.sv
// rtl/montgomery_exp_ctrl.sv - square-and-multiply modexp sequencer around one Montgomery multiplier (option: SKIP_LEADING_ZEROS_EN)
module montgomery_exp_ctrl #(
  parameter int EXP_W = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [511:0]     in_x,
  input  logic [EXP_W-1:0] in_e,
  input  logic [511:0]     in_m,
  input  logic [511:0]     in_r,
  input  logic [511:0]     in_r2,
  output logic             busy,
  output logic             done,
  output logic [511:0]     result,
  output logic             mm_start,
  output logic [511:0]     mm_a,
  output logic [511:0]     mm_b,
  output logic [511:0]     mm_m,
  input  logic [511:0]     mm_result,
  input  logic             mm_done
);

  localparam int IW = $clog2(EXP_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SKIP, S_FIN} state_t;
  typedef enum logic [1:0] {OP_TOX, OP_SQR, OP_MUL, OP_OUT} op_t;

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  op_t              w_op_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;

  logic [511:0]     r_x;
  logic [EXP_W-1:0] r_e;
  logic [511:0]     r_m;
  logic [511:0]     r_r2;
  logic [511:0]     r_a;
  logic [511:0]     r_xm;
  logic [511:0]     r_result;

  logic             w_accept;
  logic             w_capture;
  logic             w_e_bit;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_capture = (r_state == S_WAIT) && mm_done;
  assign w_e_bit   = r_e[r_idx];

  // control registers: FSM state, current op and exponent bit index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_op    <= OP_TOX;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // next state / next op; bit 0 finishing its SQR (and MUL) hands over to OUT
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_op_nxt    = OP_TOX;
          w_idx_nxt   = IDX_TOP;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mm_done) begin
          w_state_nxt = S_ISSUE;
          case (r_op)
            OP_TOX: begin
`ifdef SKIP_LEADING_ZEROS_EN
              if (r_e == '0) begin
                w_op_nxt = OP_OUT;
              end else if (w_e_bit) begin
                w_op_nxt = OP_SQR;
              end else begin
                w_state_nxt = S_SKIP;
                w_idx_nxt   = r_idx - IW'(1);
              end
`else
              w_op_nxt = OP_SQR;
`endif
            end
            OP_SQR: begin
              if (w_e_bit) begin
                w_op_nxt = OP_MUL;
              end else if (r_idx == '0) begin
                w_op_nxt = OP_OUT;
              end else begin
                w_op_nxt  = OP_SQR;
                w_idx_nxt = r_idx - IW'(1);
              end
            end
            OP_MUL: begin
              if (r_idx == '0) begin
                w_op_nxt = OP_OUT;
              end else begin
                w_op_nxt  = OP_SQR;
                w_idx_nxt = r_idx - IW'(1);
              end
            end
            default: w_state_nxt = S_FIN;
          endcase
        end
      end
      S_SKIP: begin
        // exponent is known non-zero here, so a set bit is always found
        if (w_e_bit) begin
          w_state_nxt = S_ISSUE;
          w_op_nxt    = OP_SQR;
        end else begin
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand latch on accept; multiplier result capture by op
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_r2     <= '0;
      r_a      <= '0;
      r_xm     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_x  <= in_x;
      r_e  <= in_e;
      r_m  <= in_m;
      r_r2 <= in_r2;
      r_a  <= in_r;
    end else if (w_capture) begin
      case (r_op)
        OP_TOX:  r_xm     <= mm_result;
        OP_SQR:  r_a      <= mm_result;
        OP_MUL:  r_a      <= mm_result;
        default: r_result <= mm_result;
      endcase
    end
  end

  // operand mux; held constant through WAIT because A/Xm only change on capture
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    if (r_state == S_ISSUE || r_state == S_WAIT) begin
      case (r_op)
        OP_TOX:  begin mm_a = r_x; mm_b = r_r2;   end
        OP_SQR:  begin mm_a = r_a; mm_b = r_a;    end
        OP_MUL:  begin mm_a = r_a; mm_b = r_xm;   end
        default: begin mm_a = r_a; mm_b = 512'd1; end
      endcase
    end
  end

  assign busy     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_SKIP);
  assign done     = (r_state == S_FIN);
  assign mm_start = (r_state == S_ISSUE);
  assign mm_m     = r_m;
  assign result   = r_result;

endmodule
